raizing_gp9001_cpuif: RTL and testbench

RAIZING_GP9001_CPUIF -- requirements
Module: raizing_gp9001_cpuif

---
 rtl/raizing_gp9001_cpuif.sv | 149 ++++++++++++++
 tb/tb_raizing_gp9001_cpuif.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/raizing_gp9001_cpuif.sv
// 68000 bus front end for the GP9001 GCU: decodes CPU accesses into
// one-hot GCU operations and answers status/unused offsets locally.
module raizing_gp9001_cpuif (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CPU_CS,
    input  logic        CPU_RNW,
    input  logic [2:0]  CPU_ADDR,
    input  logic [15:0] CPU_DIN,
    output logic [15:0] CPU_DOUT,
    output logic        CPU_DTACKn,
    input  logic        HSYNC,
    input  logic        VSYNC,
    input  logic        FBLANK,
    output logic        GP9001CS,
    input  logic        GP9001ACK,
    output logic [15:0] GP9001DIN,
    input  logic [15:0] GP9001DOUT,
    output logic        GP9001_OP_SELECT_REG,
    output logic        GP9001_OP_WRITE_REG,
    output logic        GP9001_OP_WRITE_RAM,
    output logic        GP9001_OP_READ_RAM_H,
    output logic        GP9001_OP_READ_RAM_L,
    output logic        GP9001_OP_SET_RAM_PTR,
    output logic        TIMEOUT
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [5:0] OP_SEL  = 6'b100000;
    localparam logic [5:0] OP_WREG = 6'b010000;
    localparam logic [5:0] OP_WRAM = 6'b001000;
    localparam logic [5:0] OP_RH   = 6'b000100;
    localparam logic [5:0] OP_RL   = 6'b000010;
    localparam logic [5:0] OP_PTR  = 6'b000001;

    state_t      state;
    logic [5:0]  op_q;
    logic [5:0]  dec_op;
    logic [15:0] local_dout;
    logic [7:0]  wait_cnt;
    logic        cs_q;
    logic        armed;
    logic        rnw_q;
    logic        aborted;
    logic        cs_rise;

    // armed blocks a CS already high at reset release from looking like an edge
    assign cs_rise = CPU_CS & ~cs_q & armed;

    always_comb begin
        dec_op = '0;
        unique case ({CPU_RNW, CPU_ADDR})
            4'b0000:          dec_op = OP_PTR;
            4'b0010, 4'b0011: dec_op = OP_WRAM;
            4'b0100:          dec_op = OP_SEL;
            4'b0110:          dec_op = OP_WREG;
            4'b1010:          dec_op = OP_RH;
            4'b1011:          dec_op = OP_RL;
            default:          dec_op = '0;
        endcase
    end

    assign local_dout = CPU_ADDR[0] ? 16'hFFFF
                                    : {HSYNC, VSYNC, FBLANK, 13'h0000};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            op_q       <= '0;
            GP9001CS   <= 1'b0;
            GP9001DIN  <= '0;
            CPU_DOUT   <= '0;
            CPU_DTACKn <= 1'b1;
            TIMEOUT    <= 1'b0;
            wait_cnt   <= '0;
            cs_q       <= 1'b0;
            armed      <= 1'b0;
            rnw_q      <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            cs_q <= CPU_CS;
            if (!CPU_CS)
                armed <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (cs_rise) begin
                        rnw_q   <= CPU_RNW;
                        aborted <= 1'b0;
                        if (dec_op != '0) begin
                            op_q      <= dec_op;
                            GP9001CS  <= 1'b1;
                            GP9001DIN <= CPU_DIN;
                            state     <= REQ;
                        end else begin
                            if (CPU_RNW)
                                CPU_DOUT <= local_dout;
                            CPU_DTACKn <= 1'b0;
                            state      <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (!CPU_CS)
                        aborted <= 1'b1;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (GP9001ACK || wait_cnt == 8'd254) begin
                        GP9001CS <= 1'b0;
                        op_q     <= '0;
                        if (!GP9001ACK) begin
                            CPU_DOUT <= 16'hFFFF;
                            TIMEOUT  <= 1'b1;
                        end else if (rnw_q) begin
                            CPU_DOUT <= GP9001DOUT;
                        end
                        // an abandoned CPU cycle must not see a stray DTACK
                        if (aborted || !CPU_CS) begin
                            state <= IDLE;
                        end else begin
                            CPU_DTACKn <= 1'b0;
                            state      <= DONE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (!CPU_CS)
                            aborted <= 1'b1;
                    end
                end
                DONE: begin
                    if (!CPU_CS) begin
                        CPU_DTACKn <= 1'b1;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

    assign GP9001_OP_SELECT_REG  = op_q[5];
    assign GP9001_OP_WRITE_REG   = op_q[4];
    assign GP9001_OP_WRITE_RAM   = op_q[3];
    assign GP9001_OP_READ_RAM_H  = op_q[2];
    assign GP9001_OP_READ_RAM_L  = op_q[1];
    assign GP9001_OP_SET_RAM_PTR = op_q[0];

endmodule

// File: tb/tb_raizing_gp9001_cpuif.sv
// Scoreboard bench for raizing_gp9001_cpuif: CPU cycles in, expected
// results queued at drive time and popped when DTACK answers.
module tb_raizing_gp9001_cpuif;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CPU_CS;
    logic        CPU_RNW;
    logic [2:0]  CPU_ADDR;
    logic [15:0] CPU_DIN;
    logic [15:0] CPU_DOUT;
    logic        CPU_DTACKn;
    logic        HSYNC;
    logic        VSYNC;
    logic        FBLANK;
    logic        GP9001CS;
    logic        GP9001ACK;
    logic [15:0] GP9001DIN;
    logic [15:0] GP9001DOUT;
    logic        op_sel, op_wreg, op_wram, op_rh, op_rl, op_ptr;
    logic        TIMEOUT;

    wire [5:0] ops = {op_sel, op_wreg, op_wram, op_rh, op_rl, op_ptr};

    raizing_gp9001_cpuif dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_CS(CPU_CS), .CPU_RNW(CPU_RNW), .CPU_ADDR(CPU_ADDR),
        .CPU_DIN(CPU_DIN), .CPU_DOUT(CPU_DOUT), .CPU_DTACKn(CPU_DTACKn),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .FBLANK(FBLANK),
        .GP9001CS(GP9001CS), .GP9001ACK(GP9001ACK),
        .GP9001DIN(GP9001DIN), .GP9001DOUT(GP9001DOUT),
        .GP9001_OP_SELECT_REG(op_sel), .GP9001_OP_WRITE_REG(op_wreg),
        .GP9001_OP_WRITE_RAM(op_wram), .GP9001_OP_READ_RAM_H(op_rh),
        .GP9001_OP_READ_RAM_L(op_rl), .GP9001_OP_SET_RAM_PTR(op_ptr),
        .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rnw;
        logic [2:0]  addr;
        logic [15:0] din;
        logic [2:0]  sync;
        int          d;
        logic [15:0] ack_data;
        logic [5:0]  op;
        logic [15:0] dout;
        logic        tmo;
        int          gcs;
        int          lat;
    } vec_t;

    vec_t exp_q[$];
    vec_t vecs[$];

    int          n_vec = 0;
    int          n_bad = 0;
    int          hi_cnt;
    int          ack_at;
    logic        ack_en;
    logic [5:0]  op_acc;
    logic        op_err;
    logic        gdin_err;
    logic [15:0] gdin0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // one cycle plus the GCU responder model, all in the stimulus process
    task automatic tick();
        @(negedge CLK);
        if (GP9001CS) begin
            hi_cnt++;
            op_acc |= ops;
            if ($countones(ops) != 1)
                op_err = 1'b1;
            if (hi_cnt == 1)
                gdin0 = GP9001DIN;
            else if (GP9001DIN !== gdin0)
                gdin_err = 1'b1;
        end else if (ops != 6'b0) begin
            op_err = 1'b1;
        end
        GP9001ACK = ack_en && GP9001CS && (hi_cnt == ack_at);
    endtask

    task automatic start(logic rnw, logic [2:0] addr, logic [15:0] din);
        hi_cnt   = 0;
        op_acc   = '0;
        op_err   = 1'b0;
        gdin_err = 1'b0;
        CPU_RNW  = rnw;
        CPU_ADDR = addr;
        CPU_DIN  = din;
        CPU_CS   = 1'b1;
    endtask

    task automatic run_vec(vec_t v);
        vec_t e;
        int   lat;
        GP9001DOUT = v.ack_data;
        ack_at = v.d + 1;
        ack_en = 1'b1;
        {HSYNC, VSYNC, FBLANK} = v.sync;
        start(v.rnw, v.addr, v.din);
        exp_q.push_back(v);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (CPU_DTACKn && lat < 400);
        e = exp_q.pop_front();
        check("dtack", {31'b0, CPU_DTACKn}, 32'd0);
        check("latency", lat, e.lat);
        check("dout", {16'b0, CPU_DOUT}, {16'b0, e.dout});
        check("op", {26'b0, op_acc}, {26'b0, e.op});
        check("gcs_cycles", hi_cnt, e.gcs);
        check("timeout", {31'b0, TIMEOUT}, {31'b0, e.tmo});
        check("onehot", {31'b0, op_err}, 32'd0);
        check("gdin_stable", {31'b0, gdin_err}, 32'd0);
        check("gcs_end", {31'b0, GP9001CS}, 32'd0);
        if (e.gcs > 0)
            check("gdin", {16'b0, gdin0}, {16'b0, e.din});
        CPU_CS = 1'b0;
        tick();
        tick();
        check("dtack_release", {31'b0, CPU_DTACKn}, 32'd1);
    endtask

    function automatic vec_t mk(logic rnw, logic [2:0] addr,
                                logic [15:0] din, logic [2:0] sync,
                                int d, logic [15:0] ackd, logic [5:0] op,
                                logic [15:0] dout, logic tmo,
                                int gcs, int lat);
        vec_t v;
        v.rnw = rnw; v.addr = addr; v.din = din; v.sync = sync;
        v.d = d; v.ack_data = ackd; v.op = op; v.dout = dout;
        v.tmo = tmo; v.gcs = gcs; v.lat = lat;
        return v;
    endfunction

    localparam logic [5:0] SEL  = 6'b100000;
    localparam logic [5:0] WREG = 6'b010000;
    localparam logic [5:0] WRAM = 6'b001000;
    localparam logic [5:0] RH   = 6'b000100;
    localparam logic [5:0] RL   = 6'b000010;
    localparam logic [5:0] PTR  = 6'b000001;

    initial begin
        logic saw_dtack;
        RESET = 1'b1;
        CPU_CS = 1'b0; CPU_RNW = 1'b1; CPU_ADDR = '0; CPU_DIN = '0;
        {HSYNC, VSYNC, FBLANK} = 3'b000;
        GP9001ACK = 1'b0; GP9001DOUT = '0;
        ack_en = 1'b0; ack_at = 0; hi_cnt = 0;
        op_acc = '0; op_err = 1'b0; gdin_err = 1'b0; gdin0 = '0;
        tick();
        tick();
        check("rst_dtack", {31'b0, CPU_DTACKn}, 32'd1);
        check("rst_gcs", {31'b0, GP9001CS}, 32'd0);
        check("rst_ops", {26'b0, ops}, 32'd0);
        check("rst_dout", {16'b0, CPU_DOUT}, 32'd0);
        check("rst_gdin", {16'b0, GP9001DIN}, 32'd0);
        check("rst_timeout", {31'b0, TIMEOUT}, 32'd0);
        RESET = 1'b0;
        tick();
        tick();

        //               rnw addr din      sync  d  ack      op    dout     tmo gcs lat
        vecs.push_back(mk(0, 4, 16'h0012, 3'b000, 3, 16'h0000, SEL,  16'h0000, 0, 4, 5));
        vecs.push_back(mk(1, 3, 16'h0000, 3'b000, 3, 16'hBEEF, RL,   16'hBEEF, 0, 4, 5));
        vecs.push_back(mk(0, 1, 16'hDEAD, 3'b000, 1, 16'h0000, 6'b0, 16'hBEEF, 0, 0, 1));
        vecs.push_back(mk(1, 6, 16'h0000, 3'b011, 1, 16'h0000, 6'b0, 16'h6000, 0, 0, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 3'b110, 1, 16'h0000, 6'b0, 16'hC000, 0, 0, 1));
        vecs.push_back(mk(1, 2, 16'h0000, 3'b000, 1, 16'h1234, RH,   16'h1234, 0, 2, 3));
        vecs.push_back(mk(1, 7, 16'h0000, 3'b111, 1, 16'h0000, 6'b0, 16'hFFFF, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0100, 3'b000, 1, 16'h0000, PTR,  16'hFFFF, 0, 2, 3));
        vecs.push_back(mk(0, 6, 16'hA5A5, 3'b000, 2, 16'h0000, WREG, 16'hFFFF, 0, 3, 4));
        vecs.push_back(mk(0, 2, 16'h5555, 3'b000, 1, 16'h0000, WRAM, 16'hFFFF, 0, 2, 3));
        vecs.push_back(mk(1, 4, 16'h0000, 3'b000, 1, 16'h0000, 6'b0, 16'h0000, 0, 0, 1));
        // ACK only during REQ must be ignored, so this one times out
        vecs.push_back(mk(1, 2, 16'h0000, 3'b000, 0, 16'h1111, RH,   16'hFFFF, 1, 256, 257));
        vecs.push_back(mk(0, 3, 16'h7777, 3'b000, 1, 16'h0000, WRAM, 16'hFFFF, 1, 2, 3));
        foreach (vecs[i])
            run_vec(vecs[i]);

        // CPU abandons the cycle while the GCU is still busy
        GP9001DOUT = 16'h9999;
        ack_en = 1'b1;
        ack_at = 10;
        start(1'b0, 3'd0, 16'h0042);
        repeat (4) tick();
        CPU_CS = 1'b0;
        saw_dtack = 1'b0;
        repeat (30) begin
            tick();
            if (!CPU_DTACKn)
                saw_dtack = 1'b1;
        end
        check("abort_dtack", {31'b0, saw_dtack}, 32'd0);
        check("abort_gcs_cycles", hi_cnt, 10);
        check("abort_gcs_end", {31'b0, GP9001CS}, 32'd0);
        check("abort_op", {26'b0, op_acc}, {26'b0, PTR});
        check("abort_dout", {16'b0, CPU_DOUT}, 32'h0000FFFF);
        run_vec(mk(1, 3, 16'h0000, 3'b000, 1, 16'h0F0F, RL, 16'h0F0F, 1, 2, 3));

        // reset in WAIT with CS held high through release
        ack_en = 1'b0;
        start(1'b0, 3'd4, 16'h0033);
        repeat (4) tick();
        check("pre_reset_gcs", {31'b0, GP9001CS}, 32'd1);
        RESET = 1'b1;
        #1;
        check("mid_rst_gcs", {31'b0, GP9001CS}, 32'd0);
        check("mid_rst_ops", {26'b0, ops}, 32'd0);
        check("mid_rst_gdin", {16'b0, GP9001DIN}, 32'd0);
        check("mid_rst_dout", {16'b0, CPU_DOUT}, 32'd0);
        check("mid_rst_dtack", {31'b0, CPU_DTACKn}, 32'd1);
        check("mid_rst_timeout", {31'b0, TIMEOUT}, 32'd0);
        tick();
        RESET = 1'b0;
        hi_cnt = 0;
        op_acc = '0;
        repeat (10) tick();
        check("post_rst_gcs_cycles", hi_cnt, 0);
        check("post_rst_dtack", {31'b0, CPU_DTACKn}, 32'd1);
        CPU_CS = 1'b0;
        tick();
        run_vec(mk(0, 4, 16'h0012, 3'b000, 2, 16'h0000, SEL, 16'h0000, 0, 3, 4));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
